// File: rtl/trap_ctrl.sv
// Trap sequencer: synchronises interrupt lines, picks the EX boundary for trap entry,
// and sequences MRET and WFI. Define TRAP_CTRL_VECTORED_EN for vectored mtvec targets.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_ADDR  = 32'h0001_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr_ex,
  input  logic        intr_t,
  input  logic        csr_mstatus_mie,
  input  logic        csr_mie_meie,
  input  logic        csr_mie_mtie,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] E_pc,
  input  logic        E_valid,
  input  logic        stall,
  input  logic        is_mret,
  input  logic        is_wfi,
  output logic        trap_enter,
  output logic        trap_return,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        sleep
);
  typedef enum logic [1:0] {IDLE, ENTER, RETURN, SLEEP} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trap_enter_q, trap_return_q, flush_q, rv_q, sleep_q;
  logic [31:0]            mepc_q, mcause_q, rpc_q, wfi_pc_q;

  logic        ex_s, ex_pend, t_pend, pend, take, boundary;
  logic [3:0]  cause_code;
  logic [31:0] cause_sel, enter_pc;

  assign ex_s       = sync_q[SYNC_STAGES-1];
  assign ex_pend    = ex_s & csr_mie_meie;
  assign t_pend     = intr_t & csr_mie_mtie;
  assign pend       = ex_pend | t_pend;
  assign take       = pend & csr_mstatus_mie;
  assign boundary   = E_valid & ~stall;
  assign cause_code = ex_pend ? 4'd11 : 4'd7;
  assign cause_sel  = {1'b1, 27'd0, cause_code};

`ifdef TRAP_CTRL_VECTORED_EN
  assign enter_pc = {MTVEC_ADDR[31:2] + {26'd0, cause_code}, 2'b00};
`else
  assign enter_pc = MTVEC_ADDR;
`endif

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], intr_ex};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      trap_enter_q  <= 1'b0;
      trap_return_q <= 1'b0;
      flush_q       <= 1'b0;
      rv_q          <= 1'b0;
      sleep_q       <= 1'b0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      rpc_q         <= '0;
      wfi_pc_q      <= '0;
    end else begin
      trap_enter_q  <= 1'b0;
      trap_return_q <= 1'b0;
      flush_q       <= 1'b0;
      rv_q          <= 1'b0;
      rpc_q         <= '0;
      case (state_q)
        IDLE: begin
          sleep_q <= 1'b0;
          if (take && boundary) begin
            state_q      <= ENTER;
            trap_enter_q <= 1'b1;
            flush_q      <= 1'b1;
            rv_q         <= 1'b1;
            rpc_q        <= enter_pc;
            mepc_q       <= E_pc;
            mcause_q     <= cause_sel;
          end else if (is_mret && boundary) begin
            state_q       <= RETURN;
            trap_return_q <= 1'b1;
            flush_q       <= 1'b1;
            rv_q          <= 1'b1;
          end else if (is_wfi && boundary && !pend) begin
            state_q  <= SLEEP;
            sleep_q  <= 1'b1;
            wfi_pc_q <= E_pc;
          end
        end
        ENTER, RETURN: state_q <= IDLE;
        SLEEP: begin
          // Wake ignores mstatus.MIE; with MIE clear we just fall through past the WFI.
          if (pend) begin
            sleep_q <= 1'b0;
            if (csr_mstatus_mie) begin
              state_q      <= ENTER;
              trap_enter_q <= 1'b1;
              flush_q      <= 1'b1;
              rv_q         <= 1'b1;
              rpc_q        <= enter_pc;
              mepc_q       <= wfi_pc_q + 32'd4;
              mcause_q     <= cause_sel;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trap_enter     = trap_enter_q;
  assign trap_return    = trap_return_q;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  // MRET target is taken live from the CSR during the RETURN cycle.
  assign redirect_pc    = (state_q == RETURN) ? csr_mepc : rpc_q;
  assign sleep          = sleep_q;
  assign mepc_o         = mepc_q;
  assign mcause_o       = mcause_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: table-driven trap entry plus MRET/WFI/stall/reset sequences.
module tb_trap_ctrl;
  localparam logic [31:0] MTVEC = 32'h0001_0000;
  localparam logic [31:0] C_EXT = 32'h8000_000B;
  localparam logic [31:0] C_TMR = 32'h8000_0007;

  logic clk = 1'b0;
  logic rst, intr_ex, intr_t, mstatus_mie, meie, mtie, E_valid, stall, is_mret, is_wfi;
  logic [31:0] csr_mepc, E_pc;
  logic trap_enter, trap_return, flush, redirect_valid, sleep;
  logic [31:0] mepc_o, mcause_o, redirect_pc;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .intr_ex(intr_ex), .intr_t(intr_t),
    .csr_mstatus_mie(mstatus_mie), .csr_mie_meie(meie), .csr_mie_mtie(mtie),
    .csr_mepc(csr_mepc), .E_pc(E_pc), .E_valid(E_valid), .stall(stall),
    .is_mret(is_mret), .is_wfi(is_wfi), .trap_enter(trap_enter), .trap_return(trap_return),
    .mepc_o(mepc_o), .mcause_o(mcause_o), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .sleep(sleep)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct { logic [31:0] cause, mepc, rpc; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic pre_ex, ex, t, meie, mtie;
    logic [31:0] pc, cause;
    int lat;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] exp_rpc(input logic [31:0] cause);
`ifdef TRAP_CTRL_VECTORED_EN
    return MTVEC + (cause & 32'hF) * 4;
`else
    return MTVEC;
`endif
  endfunction

  function automatic exp_t mk(input logic [31:0] cause, input logic [31:0] pc);
    exp_t e;
    e.cause = cause; e.mepc = pc; e.rpc = exp_rpc(cause);
    return e;
  endfunction

  task automatic idle_in();
    intr_ex = 0; intr_t = 0; mstatus_mie = 0; meie = 0; mtie = 0; csr_mepc = 0;
    E_pc = 0; E_valid = 1; stall = 0; is_mret = 0; is_wfi = 0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; step(); rst = 0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_te"}, 32'(trap_enter), 0);
    chk({nm, "_tr"}, 32'(trap_return), 0);
    chk({nm, "_fl"}, 32'(flush), 0);
    chk({nm, "_rv"}, 32'(redirect_valid), 0);
    chk({nm, "_rpc"}, redirect_pc, 0);
    chk({nm, "_sl"}, 32'(sleep), 0);
    chk({nm, "_mepc"}, mepc_o, 0);
    chk({nm, "_mc"}, mcause_o, 0);
  endtask

  task automatic wait_trap(input int maxc, output int lat);
    lat = 0;
    for (int c = 1; c <= maxc; c++) begin
      step();
      if (trap_enter) begin lat = c; break; end
    end
  endtask

  task automatic check_trap(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL %s_sb: got trap with empty scoreboard want none", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_mcause"}, mcause_o, e.cause);
      chk({nm, "_mepc"}, mepc_o, e.mepc);
      chk({nm, "_rpc"}, redirect_pc, e.rpc);
      chk({nm, "_flush"}, 32'(flush), 1);
      chk({nm, "_rv"}, 32'(redirect_valid), 1);
      chk({nm, "_tr"}, 32'(trap_return), 0);
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, C_EXT, 3};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, C_TMR, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h400, C_EXT, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h500, C_TMR, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 32'h0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, 32'h0, 0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h800, C_TMR, 1};

    rst = 1; idle_in();
    step(); step();
    check_zero("reset");
    rst = 0;

    foreach (vecs[i]) begin
      do_reset();
      meie = vecs[i].meie; mtie = vecs[i].mtie; intr_ex = vecs[i].pre_ex;
      repeat (4) step();
      intr_ex = vecs[i].ex; intr_t = vecs[i].t; E_pc = vecs[i].pc; mstatus_mie = 1;
      if (vecs[i].lat != 0) sb.push_back(mk(vecs[i].cause, vecs[i].pc));
      wait_trap(8, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      if (lat != 0) begin
        check_trap($sformatf("vec%0d", i));
        mstatus_mie = 0; intr_ex = 0; intr_t = 0;
        step();
        chk($sformatf("vec%0d_te_off", i), 32'(trap_enter), 0);
        chk($sformatf("vec%0d_fl_off", i), 32'(flush), 0);
        chk($sformatf("vec%0d_mepc_hold", i), mepc_o, vecs[i].pc);
      end
    end

    // MRET
    do_reset();
    csr_mepc = 32'h104; E_pc = 32'h10020; is_mret = 1;
    step();
    chk("mret_tr", 32'(trap_return), 1);
    chk("mret_te", 32'(trap_enter), 0);
    chk("mret_rpc", redirect_pc, 32'h104);
    chk("mret_fl", 32'(flush), 1);
    chk("mret_rv", 32'(redirect_valid), 1);
    is_mret = 0;
    step();
    chk("mret_tr_off", 32'(trap_return), 0);
    chk("mret_rv_off", 32'(redirect_valid), 0);

    // WFI with MIE=1, timer wake -> trap at wfi_pc+4
    do_reset();
    mstatus_mie = 1; mtie = 1; E_pc = 32'h200; is_wfi = 1;
    step();
    chk("wfi1_sleep", 32'(sleep), 1);
    is_wfi = 0; E_valid = 0;
    repeat (3) step();
    chk("wfi1_still", 32'(sleep), 1);
    chk("wfi1_fl", 32'(flush), 0);
    intr_t = 1;
    sb.push_back(mk(C_TMR, 32'h204));
    wait_trap(2, lat);
    chk("wfi1_lat", 32'(lat), 1);
    if (lat != 0) check_trap("wfi1");
    chk("wfi1_wake", 32'(sleep), 0);

    // WFI with MIE=0 -> wake without trap
    do_reset();
    mtie = 1; E_pc = 32'h200; is_wfi = 1;
    step();
    chk("wfi0_sleep", 32'(sleep), 1);
    is_wfi = 0; E_valid = 0; intr_t = 1;
    step();
    chk("wfi0_wake", 32'(sleep), 0);
    chk("wfi0_te", 32'(trap_enter), 0);
    chk("wfi0_rv", 32'(redirect_valid), 0);
    step();
    chk("wfi0_te2", 32'(trap_enter), 0);

    // WFI with interrupt already pending is a NOP
    do_reset();
    mtie = 1; intr_t = 1; E_pc = 32'h200; is_wfi = 1;
    step(); step();
    chk("wfinop_sleep", 32'(sleep), 0);

    // stall blocks entry; a line dropping under stall is lost
    do_reset();
    mstatus_mie = 1; mtie = 1; intr_t = 1; stall = 1; E_pc = 32'h900;
    repeat (3) step();
    chk("stall_te", 32'(trap_enter), 0);
    intr_t = 0; stall = 0;
    step(); step();
    chk("lost_te", 32'(trap_enter), 0);
    intr_t = 1; stall = 1;
    step();
    chk("stall2_te", 32'(trap_enter), 0);
    stall = 0;
    sb.push_back(mk(C_TMR, 32'h900));
    wait_trap(3, lat);
    chk("stall_rel_lat", 32'(lat), 1);
    if (lat != 0) check_trap("stall_rel");

    // MRET with interrupt: interrupt wins
    do_reset();
    mstatus_mie = 1; mtie = 1; intr_t = 1; is_mret = 1; E_pc = 32'h10020; csr_mepc = 32'h104;
    sb.push_back(mk(C_TMR, 32'h10020));
    wait_trap(2, lat);
    chk("mretint_lat", 32'(lat), 1);
    if (lat != 0) check_trap("mretint");

    // reset during SLEEP
    do_reset();
    E_pc = 32'h200; is_wfi = 1;
    step();
    chk("rsl_sleep", 32'(sleep), 1);
    is_wfi = 0; rst = 1;
    step();
    rst = 0;
    check_zero("rst_sleep");

    // reset during ENTER, external line stays high -> retaken after resync
    do_reset();
    mstatus_mie = 1; meie = 1; intr_ex = 1; E_pc = 32'hA00;
    sb.push_back(mk(C_EXT, 32'hA00));
    wait_trap(8, lat);
    chk("rent_lat", 32'(lat), 3);
    if (lat != 0) check_trap("rent");
    rst = 1;
    step();
    rst = 0;
    check_zero("rst_enter");
    sb.push_back(mk(C_EXT, 32'hA00));
    wait_trap(8, lat);
    chk("retake_lat", 32'(lat), 3);
    if (lat != 0) check_trap("retake");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Interrupt/trap sequencer for the CPU pipeline, alongside the CSR file.
- Synchronises the external and timer interrupt lines and arbitrates between them.
- Picks the EX-stage instruction boundary where a trap is taken.
- Drives the CSR file's trap entry/exit strobes and the pipeline's flush and PC redirect.
- Also handles MRET and WFI sleep/wake sequencing.

Parameters:
- MTVEC_ADDR, 32'h0001_0000: trap handler base address, matching the hardwired mtvec.
- SYNC_STAGES, 2: flop stages on the external interrupt input (minimum 2).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; synchronous, active-high
- intr_ex  in  1  external interrupt line, level, asynchronous
- intr_t  in  1  timer interrupt line, level, synchronous to clk
- csr_mstatus_mie  in  1  mstatus[3]
- csr_mie_meie  in  1  mie[11]
- csr_mie_mtie  in  1  mie[7]
- csr_mepc  in  32  current mepc, the MRET target
- E_pc  in  32  PC of the EX-stage instruction
- E_valid  in  1  EX stage holds a real instruction (not a bubble)
- stall  in  1  EX stage frozen this cycle
- is_mret  in  1  EX instruction is MRET
- is_wfi  in  1  EX instruction is WFI
- trap_enter  out  1  one-cycle strobe: CSR saves MIE->MPIE, clears MIE, loads mepc
- trap_return  out  1  one-cycle strobe: CSR restores MPIE->MIE, sets MPIE
- mepc_o  out  32  value for the CSR to load into mepc; valid with trap_enter
- mcause_o  out  32  0x8000000B (external) or 0x80000007 (timer); valid with trap_enter
- flush  out  1  kill IF/ID/EX contents
- redirect_valid  out  1  load redirect_pc into the PC
- redirect_pc  out  32  new fetch address
- sleep  out  1  hold fetch, WFI in progress

Behaviour:
- Reset: all outputs 0, synchroniser flops cleared, state IDLE. Reset asserted in any state wins on that edge.
- Synchronisation:
  - intr_ex passes SYNC_STAGES flops to give ex_s.
  - ex_pend = ex_s & csr_mie_meie.
  - t_pend = intr_t & csr_mie_mtie (intr_t is not synchronised).
  - Arbitration: external beats timer.
  - take = (ex_pend | t_pend) & csr_mstatus_mie.
- Commit condition: boundary = E_valid & ~stall.
- State IDLE:
  - take & boundary: go to ENTER. Latch mepc_o=E_pc and the cause. The EX instruction is not executed.
  - else is_mret & boundary: go to RETURN.
  - else is_wfi & boundary & ~(ex_pend|t_pend): go to SLEEP and latch wfi_pc=E_pc.
  - is_wfi with an interrupt already pending: the WFI is a NOP and the state stays IDLE.
- State ENTER, exactly 1 cycle:
  - trap_enter=1, flush=1, redirect_valid=1.
  - redirect_pc=MTVEC_ADDR.
  - Then go to IDLE. The CSR clears MIE, so no nested trap occurs.
- State RETURN, exactly 1 cycle:
  - trap_return=1, flush=1, redirect_valid=1.
  - redirect_pc=csr_mepc, sampled in this cycle.
  - Then go to IDLE.
- State SLEEP:
  - sleep=1, flush=0.
  - Wake on ex_pend|t_pend, regardless of mstatus.MIE.
  - If csr_mstatus_mie=1: go to ENTER with mepc_o=wfi_pc+4 and the arbitrated cause.
  - Else: go to IDLE, deassert sleep, and resume at wfi_pc+4. No redirect is issued; the front end already holds that PC.
- Latency, from intr_ex rising with enables set and continuous boundary:
  - ex_s high at edge SYNC_STAGES.
  - ENTER state one cycle later.
  - With SYNC_STAGES=2, trap_enter is high in the 3rd cycle after assertion.
  - For intr_t, trap_enter is high in the cycle after assertion.
- Lines dropping before the boundary:
  - A pending line that deasserts before a boundary is lost; interrupts are level-sensitive and nothing is latched.
  - The cause latched at ENTER entry is kept even if the line drops during ENTER.
- stall held: no transition out of IDLE. ENTER and RETURN ignore stall; flush overrides it.
- MRET and interrupt together in IDLE: the interrupt wins, mepc_o = the MRET's PC, so the MRET re-executes after the handler.
- Outputs are registered from state. mepc_o and mcause_o hold their last values outside ENTER.

Optional Feature:
- Macro: TRAP_CTRL_VECTORED_EN.
- Defined: ENTER uses redirect_pc = MTVEC_ADDR + 4*cause_code. That gives MTVEC_ADDR+0x2C for external and MTVEC_ADDR+0x1C for timer. A 30-bit add; MTVEC_ADDR[1:0] is forced to 0.
- Undefined: direct mode, redirect_pc = MTVEC_ADDR for every cause.
- MRET behaviour is identical in both builds.

Test Plan:
- mstatus.MIE=1, MEIE=1, E_valid=1, E_pc=0x100; pulse intr_ex high -> trap_enter in the 3rd cycle, mepc_o=0x100, mcause_o=0x8000000B, redirect_pc=0x00010000 (0x0001002C with VECTORED_EN), flush=1 for one cycle.
- intr_ex and intr_t both high with all enables set -> mcause_o=0x8000000B. Clear intr_ex and rerun -> 0x80000007.
- is_mret at E_pc=0x10020, csr_mepc=0x104, MIE=0 -> next cycle trap_return=1, redirect_pc=0x104, trap_enter=0.
- WFI at 0x200 with MIE=1 and no pending interrupt -> sleep=1. Then intr_t=1, MTIE=1 -> ENTER, mepc_o=0x204, sleep=0.
- WFI at 0x200 with mstatus.MIE=0; then intr_t=1, MTIE=1 -> sleep drops, no trap_enter, no redirect.
- Assert rst during SLEEP, and separately during ENTER -> next cycle every output is 0 and the state is IDLE. A pending intr_ex is re-taken only after SYNC_STAGES more cycles.
